stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
// - Hardware LIFO stack behind the decode stage. Executes the decoder's StackOp
//   field: 2'b10 = push, 2'b11 = pop.
// - Push stores the Rt register value. Pop returns the top-of-stack word to the
//   write-back mux, which selects it via MemToReg while StackOp == pop.
// - Single-cycle core: pop data is read combinationally in the same cycle;
//   all state updates on the clock edge.
// - Sticky fault state machine traps overflow/underflow until software clears it.
// PARAMETERS
// - DATA_W   32   stack word width
// - DEPTH    16   number of entries (power of 2, >= 2)
// - CNT_W    $clog2(DEPTH+1)   width of SP/Count (derived, do not override)
// PORTS
// - clk        in   1        core clock; all state changes on rising edge
// - rst_n      in   1        asynchronous, active-low reset
// - StackOp    in   2        from decoder: 00/01 none, 10 push, 11 pop
// - Stall      in   1        1 = core stalled; StackOp ignored this cycle
// - PushData   in   DATA_W   Rt read data, written on push
// - ErrClr     in   1        1-cycle pulse; leaves FAULT, clears flags
// - PopData    out  DATA_W   mem[SP-1] on a legal pop cycle, else 0 (combinational)
// - PopValid   out  1        1 during a legal, non-stalled pop in NORMAL (combinational)
// - Count      out  CNT_W    current occupancy (= SP)
// - Full       out  1        Count == DEPTH
// - Empty      out  1        Count == 0
// - Overflow   out  1        sticky: push attempted while Full
// - Underflow  out  1        sticky: pop attempted while Empty
// - Fault      out  1        1 while FSM is in FAULT
// BEHAVIOUR
// - Reset (async assert, sync release): SP = 0, state NORMAL,
//   Overflow/Underflow = 0, so Count = 0, Empty = 1, Full = 0, Fault = 0.
//   Storage array is not reset. PopData = 0 and PopValid = 0 whenever reset is asserted.
// - Op cycle: any cycle with Stall = 0 and StackOp[1] = 1. Otherwise no state changes.
// - NORMAL, push, !Full: mem[SP] <= PushData; SP <= SP+1.
// - NORMAL, push, Full: no write, SP held; Overflow <= 1; state -> FAULT.
// - NORMAL, pop, !Empty: PopData = mem[SP-1], PopValid = 1 in the same cycle;
//   SP <= SP-1 at the edge.
// - NORMAL, pop, Empty: PopData = 0, PopValid = 0; Underflow <= 1; state -> FAULT.
// - FAULT: all ops ignored. SP and memory are frozen. PopData = 0, PopValid = 0.
//   Exit only when ErrClr = 1: next state NORMAL, both flags cleared, SP retained.
// - ErrClr in NORMAL: clears nothing (flags are already 0); the op that cycle
//   still executes.
// - ErrClr and an op in the same FAULT cycle: the op is ignored; only the clear
//   takes effect.
// - Latency: push data is readable by a pop issued the very next cycle.
//   SP is never updated by more than 1 per cycle.
// - Width rules: SP stays in 0..DEPTH, with no wrap-around. Memory address is
//   SP[CNT_W-2:0] for push and (SP-1)[CNT_W-2:0] for pop.
// - Reset mid-sequence: state is lost immediately; the stack reads as empty
//   after release.
// TESTING
// - Reset, then push 0x11, 0x22, 0x33 -> Count = 3. Pop x3 -> PopData
//   0x33, 0x22, 0x11 with PopValid = 1 each cycle; Empty = 1 after.
// - Push DEPTH (16) words 0..15 -> Full = 1. A 17th push of 0xDEAD ->
//   Overflow = 1, Fault = 1, Count = 16. A following pop -> PopValid = 0, Count = 16.
// - From FAULT, pulse ErrClr -> Fault = 0, Overflow = 0. Then pop -> PopData = 15, Count = 15.
// - Reset, then pop -> Underflow = 1, PopData = 0, Fault = 1. ErrClr with push
//   0x5 in the same cycle -> push ignored, Count = 0.
// - Push 0xA with Stall = 1 -> Count unchanged. Release Stall, push 0xA, then
//   immediately pop -> PopData = 0xA.
// - Push 4 words, assert rst_n = 0 mid-cycle -> Count = 0 and Empty = 1
//   immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: LIFO stack for the decode stage with a sticky overflow/underflow fault FSM
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   StackOp, Stall      decoder stack op (10 push, 11 pop) and core stall
//   PushData            Rt value written on push
//   ErrClr              clears the fault and leaves FAULT
//   PopData, PopValid   combinational top-of-stack word on a legal pop
//   Count, Full, Empty  occupancy and its limits
//   Overflow, Underflow sticky fault causes; Fault is high while in FAULT
module stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        StackOp,
  input  logic              Stall,
  input  logic [DATA_W-1:0] PushData,
  input  logic              ErrClr,
  output logic [DATA_W-1:0] PopData,
  output logic              PopValid,
  output logic [CNT_W-1:0]  Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Underflow,
  output logic              Fault
);
  typedef enum logic {NORMAL, FAULT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] sp, sp_n, sp_dec;
  logic ovf_n, unf_n, op, push, pop, wr, rd;
  logic [DATA_W-1:0] mem [DEPTH];
  assign op     = !Stall && StackOp[1];
  assign push   = op && !StackOp[0];
  assign pop    = op && StackOp[0];
  assign sp_dec = sp - 1'b1;
  assign Count  = sp;
  assign Full   = sp == CNT_W'(DEPTH);
  assign Empty  = sp == '0;
  assign Fault  = state == FAULT;
  assign wr     = rst_n && state == NORMAL && push && !Full;
  assign rd     = rst_n && state == NORMAL && pop && !Empty;
  assign PopValid = rd;
  assign PopData  = rd ? mem[sp_dec[CNT_W-2:0]] : '0;
  always_comb begin
    state_n = state;
    sp_n    = sp;
    ovf_n   = Overflow;
    unf_n   = Underflow;
    if (state == FAULT) begin
      if (ErrClr) begin
        state_n = NORMAL;
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
      end
    end else if (push) begin
      sp_n    = Full ? sp : sp + 1'b1;
      ovf_n   = Full;
      state_n = Full ? FAULT : NORMAL;
    end else if (pop) begin
      sp_n    = Empty ? sp : sp_dec;
      unf_n   = Empty;
      state_n = Empty ? FAULT : NORMAL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NORMAL;
      sp        <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      state     <= state_n;
      sp        <= sp_n;
      Overflow  <= ovf_n;
      Underflow <= unf_n;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[sp[CNT_W-2:0]] <= PushData;
  end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit
module tb_stack_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  StackOp = 2'b00;
  logic        Stall = 0;
  logic [31:0] PushData = '0;
  logic        ErrClr = 0;
  logic [31:0] PopData;
  logic        PopValid, Full, Empty, Overflow, Underflow, Fault;
  logic [4:0]  Count;
  int vectors = 0;
  int errors = 0;
  stack_unit dut (
    .clk(clk), .rst_n(rst_n), .StackOp(StackOp), .Stall(Stall), .PushData(PushData),
    .ErrClr(ErrClr), .PopData(PopData), .PopValid(PopValid), .Count(Count), .Full(Full),
    .Empty(Empty), .Overflow(Overflow), .Underflow(Underflow), .Fault(Fault)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    StackOp = 2'b00;
    ErrClr = 0;
    Stall = 0;
  endtask
  task automatic do_push(input logic [31:0] d);
    StackOp = 2'b10;
    PushData = d;
    tick();
    idle();
  endtask
  task automatic test_reset();
    rst_n = 0;
    idle();
    #2;
    vectors++; if (Count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", Count); end
    vectors++; if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL reset_flags got E=%b F=%b exp E=1 F=0", Empty, Full); end
    vectors++; if (Fault !== 1'b0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin errors++; $display("FAIL reset_fault got %b%b%b exp 000", Fault, Overflow, Underflow); end
    StackOp = 2'b11;
    #1;
    vectors++; if (PopValid !== 1'b0 || PopData !== 32'h0) begin errors++; $display("FAIL reset_pop got v=%b d=%h exp v=0 d=0", PopValid, PopData); end
    idle();
    tick();
    rst_n = 1;
  endtask
  task automatic test_lifo();
    logic [31:0] exp_d [3] = '{32'h33, 32'h22, 32'h11};
    do_push(32'h11);
    do_push(32'h22);
    do_push(32'h33);
    vectors++; if (Count !== 5'd3) begin errors++; $display("FAIL lifo_count got %0d exp 3", Count); end
    for (int i = 0; i < 3; i++) begin
      StackOp = 2'b11;
      #1;
      vectors++; if (PopData !== exp_d[i] || PopValid !== 1'b1) begin errors++; $display("FAIL lifo_pop%0d got d=%h v=%b exp d=%h v=1", i, PopData, PopValid, exp_d[i]); end
      tick();
      idle();
    end
    vectors++; if (Empty !== 1'b1 || Count !== 5'd0) begin errors++; $display("FAIL lifo_empty got E=%b C=%0d exp E=1 C=0", Empty, Count); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) do_push(32'(i));
    vectors++; if (Full !== 1'b1 || Count !== 5'd16) begin errors++; $display("FAIL ovf_full got F=%b C=%0d exp F=1 C=16", Full, Count); end
    do_push(32'hDEAD);
    vectors++; if (Overflow !== 1'b1 || Fault !== 1'b1 || Count !== 5'd16) begin errors++; $display("FAIL ovf_fault got O=%b F=%b C=%0d exp O=1 F=1 C=16", Overflow, Fault, Count); end
    StackOp = 2'b11;
    #1;
    vectors++; if (PopValid !== 1'b0 || PopData !== 32'h0) begin errors++; $display("FAIL ovf_pop got v=%b d=%h exp v=0 d=0", PopValid, PopData); end
    tick();
    idle();
    vectors++; if (Count !== 5'd16 || Fault !== 1'b1) begin errors++; $display("FAIL ovf_frozen got C=%0d F=%b exp C=16 F=1", Count, Fault); end
  endtask
  task automatic test_clear();
    ErrClr = 1;
    tick();
    idle();
    vectors++; if (Fault !== 1'b0 || Overflow !== 1'b0 || Count !== 5'd16) begin errors++; $display("FAIL clr_state got F=%b O=%b C=%0d exp F=0 O=0 C=16", Fault, Overflow, Count); end
    StackOp = 2'b11;
    #1;
    vectors++; if (PopData !== 32'd15 || PopValid !== 1'b1) begin errors++; $display("FAIL clr_pop got d=%h v=%b exp d=f v=1", PopData, PopValid); end
    tick();
    idle();
    vectors++; if (Count !== 5'd15) begin errors++; $display("FAIL clr_count got %0d exp 15", Count); end
  endtask
  task automatic test_underflow();
    rst_n = 0;
    tick();
    rst_n = 1;
    StackOp = 2'b11;
    #1;
    vectors++; if (PopValid !== 1'b0 || PopData !== 32'h0) begin errors++; $display("FAIL unf_pop got v=%b d=%h exp v=0 d=0", PopValid, PopData); end
    tick();
    idle();
    vectors++; if (Underflow !== 1'b1 || Fault !== 1'b1 || Overflow !== 1'b0) begin errors++; $display("FAIL unf_fault got U=%b F=%b O=%b exp U=1 F=1 O=0", Underflow, Fault, Overflow); end
    ErrClr = 1;
    do_push(32'h5);
    vectors++; if (Count !== 5'd0 || Fault !== 1'b0 || Underflow !== 1'b0) begin errors++; $display("FAIL unf_clr got C=%0d F=%b U=%b exp C=0 F=0 U=0", Count, Fault, Underflow); end
  endtask
  task automatic test_errclr_normal();
    ErrClr = 1;
    do_push(32'h7);
    vectors++; if (Count !== 5'd1 || Fault !== 1'b0) begin errors++; $display("FAIL errclr_normal got C=%0d F=%b exp C=1 F=0", Count, Fault); end
    StackOp = 2'b11;
    #1;
    vectors++; if (PopData !== 32'h7) begin errors++; $display("FAIL errclr_pop got %h exp 7", PopData); end
    tick();
    idle();
  endtask
  task automatic test_back_to_back();
    Stall = 1;
    StackOp = 2'b10;
    PushData = 32'hA;
    tick();
    vectors++; if (Count !== 5'd0) begin errors++; $display("FAIL stall_push got %0d exp 0", Count); end
    Stall = 0;
    tick();
    StackOp = 2'b11;
    #1;
    vectors++; if (PopData !== 32'hA || PopValid !== 1'b1) begin errors++; $display("FAIL b2b_pop got d=%h v=%b exp d=a v=1", PopData, PopValid); end
    tick();
    idle();
    vectors++; if (Count !== 5'd0) begin errors++; $display("FAIL b2b_count got %0d exp 0", Count); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) do_push(32'(i + 8'h40));
    vectors++; if (Count !== 5'd4) begin errors++; $display("FAIL arst_pre got %0d exp 4", Count); end
    #2;
    rst_n = 0;
    #1;
    vectors++; if (Count !== 5'd0 || Empty !== 1'b1) begin errors++; $display("FAIL arst_now got C=%0d E=%b exp C=0 E=1", Count, Empty); end
    tick();
    rst_n = 1;
    tick();
    vectors++; if (Empty !== 1'b1 || Fault !== 1'b0) begin errors++; $display("FAIL arst_after got E=%b F=%b exp E=1 F=0", Empty, Fault); end
  endtask
  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_clear();
    test_underflow();
    test_errclr_normal();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
